// File: rtl/joy_zx2_tx.sv
// rtl/joy_zx2_tx.sv - ZX2 joystick link transmitter (74HC165-style 24-bit shifter)
module joy_zx2_tx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_12M,
  input  logic        RESET_N,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  input  logic [11:0] BUTTONS_P1,
  input  logic [11:0] BUTTONS_P2,
  output logic        JOY_DATA,
  output logic        FRAME_DONE,
  output logic        SHORT_FRAME
);

  localparam logic [4:0] COUNT_FULL = 5'd24;
  localparam logic [4:0] COUNT_LAST = 5'd23;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [23:0]            sr_q, sr_d;
  logic [4:0]             count_q, count_d;
  logic                   frame_done_q, frame_done_d;
  logic                   short_frame_q, short_frame_d;
  logic                   clk_rise;
  logic                   load_n;

  // Host wire order, bit 0 leaves first.
  function automatic logic [23:0] frame_of(input logic [11:0] p1, input logic [11:0] p2);
    frame_of = {p1[7], p1[9], p1[11], p1[10], p2[7], p2[9], p2[11], p2[10],
                p2[0], p2[1], p2[2], p2[3], p2[4], p2[5], p2[6], p2[8],
                p1[0], p1[1], p1[2], p1[3], p1[4], p1[5], p1[6], p1[8]};
  endfunction

  // Synchronizers, edge detect, and load/shift next-state; load beats a coincident clock edge.
  always_comb begin
    clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], JOY_CLK};
    load_sync_d   = {load_sync_q[SYNC_STAGES-2:0], JOY_LOAD};
    clk_prev_d    = clk_sync_q[SYNC_STAGES-1];
    clk_rise      = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    load_n        = load_sync_q[SYNC_STAGES-1];
    sr_d          = sr_q;
    count_d       = count_q;
    frame_done_d  = 1'b0;
    short_frame_d = 1'b0;
    if (!load_n) begin
      sr_d          = frame_of(BUTTONS_P1, BUTTONS_P2);
      count_d       = 5'd0;
      // Count is forced to 0 here, so only the first load cycle can flag a truncated frame.
      short_frame_d = (count_q != 5'd0) && (count_q != COUNT_FULL);
    end else if (clk_rise) begin
      sr_d         = {1'b1, sr_q[23:1]};
      count_d      = (count_q == COUNT_FULL) ? COUNT_FULL : count_q + 5'd1;
      frame_done_d = (count_q == COUNT_LAST);
    end
  end

  // State register; reset parks everything high so releasing reset with JOY_CLK high makes no edge.
  always_ff @(posedge CLK_12M) begin
    if (!RESET_N) begin
      clk_sync_q    <= '1;
      load_sync_q   <= '1;
      clk_prev_q    <= 1'b1;
      sr_q          <= '1;
      count_q       <= COUNT_FULL;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      load_sync_q   <= load_sync_d;
      clk_prev_q    <= clk_prev_d;
      sr_q          <= sr_d;
      count_q       <= count_d;
      frame_done_q  <= frame_done_d;
      short_frame_q <= short_frame_d;
    end
  end

  assign JOY_DATA    = sr_q[0];
  assign FRAME_DONE  = frame_done_q;
  assign SHORT_FRAME = short_frame_q;

endmodule

// File: tb/tb_joy_zx2_tx.sv
// tb/tb_joy_zx2_tx.sv - scoreboard bench for joy_zx2_tx
module tb_joy_zx2_tx;

  localparam logic [1:0] EV_FD = 2'b01;
  localparam logic [1:0] EV_SF = 2'b10;

  logic        clk;
  logic        resetn;
  logic        joy_clk;
  logic        joy_load;
  logic [11:0] p1;
  logic [11:0] p2;
  logic        joy_data;
  logic        frame_done;
  logic        short_frame;

  logic       exp_q[$];
  logic [1:0] ev_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         smp   = 0;

  joy_zx2_tx #(.SYNC_STAGES(2)) dut (
    .CLK_12M    (clk),
    .RESET_N    (resetn),
    .JOY_CLK    (joy_clk),
    .JOY_LOAD   (joy_load),
    .BUTTONS_P1 (p1),
    .BUTTONS_P2 (p2),
    .JOY_DATA   (joy_data),
    .FRAME_DONE (frame_done),
    .SHORT_FRAME(short_frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Host sampling point: JOY_DATA at each JOY_CLK rise against the queued bit.
  always @(posedge joy_clk) begin
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sample %0d: unexpected host clock, data=%b", smp, joy_data);
    end else begin
      logic e;
      e = exp_q.pop_front();
      if (joy_data !== e) begin
        n_err++;
        $display("FAIL sample %0d: joy_data=%b expected=%b", smp, joy_data, e);
      end
    end
    smp++;
  end

  // Pulse monitor: every FRAME_DONE/SHORT_FRAME pulse must match the next queued event.
  always @(negedge clk) begin
    if (frame_done === 1'b1 || short_frame === 1'b1) begin
      n_vec++;
      if (ev_q.size() == 0) begin
        n_err++;
        $display("FAIL pulse: got {short,done}=%b expected none", {short_frame, frame_done});
      end else begin
        logic [1:0] e;
        e = ev_q.pop_front();
        if ({short_frame, frame_done} !== e) begin
          n_err++;
          $display("FAIL pulse: got {short,done}=%b expected=%b", {short_frame, frame_done}, e);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_clk(input logic e);
    exp_q.push_back(e);
    joy_clk = 1'b1;
    wait_cyc(8);
    joy_clk = 1'b0;
    wait_cyc(8);
  endtask

  task automatic pulse_load();
    joy_load = 1'b0;
    wait_cyc(8);
    joy_load = 1'b1;
    wait_cyc(8);
  endtask

  task automatic run_frame(input logic [23:0] f, input int n);
    for (int i = 0; i < n; i++) host_clk((i < 24) ? f[i] : 1'b1);
  endtask

  initial begin
    resetn   = 1'b0;
    joy_clk  = 1'b0;
    joy_load = 1'b1;
    p1       = 12'hFFF;
    p2       = 12'hFFF;
    wait_cyc(4);
    resetn = 1'b1;
    wait_cyc(4);

    // Reset state: idle high, no pulses.
    host_clk(1'b1);

    // Full frame: up on P1 -> bit 7, test on P2 -> bit 17.
    p1 = 12'hFFE; p2 = 12'h7FF;
    pulse_load();
    ev_q.push_back(EV_FD);
    run_frame(24'hFDFF7F, 24);

    // Snapshot isolation.
    p1 = 12'hFFF; p2 = 12'hFFF;
    pulse_load();
    ev_q.push_back(EV_FD);
    for (int i = 0; i < 24; i++) begin
      host_clk(1'b1);
      if (i == 2) p1 = 12'h000;
    end
    p1 = 12'hFFF;

    // Short frame: reload after 10 shifts with start pressed.
    pulse_load();
    run_frame(24'hFFFFFF, 10);
    ev_q.push_back(EV_SF);
    p1 = 12'hEFF;
    pulse_load();
    ev_q.push_back(EV_FD);
    run_frame(24'hFFFFFE, 24);

    // Overclock: all pressed, 30 clocks.
    p1 = 12'h000; p2 = 12'h000;
    pulse_load();
    ev_q.push_back(EV_FD);
    run_frame(24'h000000, 30);

    // Load/clock collision: load_n low for exactly the clk_rise cycle.
    p1 = 12'h5A5; p2 = 12'hA5A;
    exp_q.push_back(1'b1);
    joy_load = 1'b0;
    joy_clk  = 1'b1;
    wait_cyc(1);
    joy_load = 1'b1;
    wait_cyc(7);
    joy_clk = 1'b0;
    wait_cyc(8);
    ev_q.push_back(EV_FD);
    run_frame(24'h965AA5, 24);

    // Reset mid-frame, released with JOY_CLK high.
    p1 = 12'hFFE; p2 = 12'h7FF;
    pulse_load();
    run_frame(24'hFDFF7F, 5);
    resetn = 1'b0;
    wait_cyc(1);
    exp_q.push_back(1'b1);
    joy_clk = 1'b1;
    wait_cyc(2);
    resetn = 1'b1;
    wait_cyc(8);
    joy_clk = 1'b0;
    wait_cyc(8);
    host_clk(1'b1);
    pulse_load();
    ev_q.push_back(EV_FD);
    run_frame(24'hFDFF7F, 24);

    wait_cyc(20);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL data_queue: %0d samples left, expected 0", exp_q.size());
    end
    n_vec++;
    if (ev_q.size() != 0) begin
      n_err++;
      $display("FAIL pulse_queue: %0d pulses missing, expected 0", ev_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
